// File: rtl/ma_stage.sv
// ============================================================================
// ma_stage : memory-access stage, word-organised data RAM with registered load
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module ma_stage #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] aluResult,
  input  logic [31:0] op2,
  input  logic        isLd,
  input  logic        isSt,
  output logic [31:0] ldResult
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0]           mem_q [c_DEPTH];
  logic [DEPTH_LOG2-1:0] w_index;
  logic [31:0]           ldResult_d;
  logic [31:0]           ldResult_q;
  logic                  w_wr_en;
  logic                  w_unused_addr;

  // Byte offset and bits above the array size are dropped: accesses alias.
  assign w_index       = aluResult[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{aluResult[31:DEPTH_LOG2+2], aluResult[1:0]};

  // Stores are blocked while reset is held; the array itself is never cleared.
  assign w_wr_en = isSt & reset;

  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      mem_q[w_index] <= op2;
    end
  end

  // Reads the pre-edge word, giving read-before-write on simultaneous ld/st.
  always_comb begin
    ldResult_d = ldResult_q;
    if (isLd) begin
      ldResult_d = mem_q[w_index];
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      ldResult_q <= 32'h0000_0000;
    end else begin
      ldResult_q <= ldResult_d;
    end
  end

  assign ldResult = ldResult_q;

endmodule

`default_nettype wire

// File: tb/tb_ma_stage.sv
// ============================================================================
// tb_ma_stage : directed self-checking bench for ma_stage
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_ma_stage;

  logic        Clk;
  logic        reset;
  logic [31:0] aluResult;
  logic [31:0] op2;
  logic        isLd;
  logic        isSt;
  logic [31:0] ldResult;

  int checks = 0;
  int errors = 0;

  ma_stage #(.DEPTH_LOG2(10)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .aluResult (aluResult),
    .op2       (op2),
    .isLd      (isLd),
    .isSt      (isSt),
    .ldResult  (ldResult)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access: inputs applied between edges, results sampled 1ns after the edge.
  task automatic cyc(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
    isLd      = ld;
    isSt      = st;
    aluResult = a;
    op2       = d;
    @(posedge Clk);
    #1;
    isLd = 1'b0;
    isSt = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    isLd      = 1'b1;
    isSt      = 1'b0;
    aluResult = 32'h0;
    op2       = 32'h0;
    #2;
    check("reset_async_initial", ldResult, 32'h0);
    @(posedge Clk);
    #1;
    check("reset_hold_during_load", ldResult, 32'h0);
    isLd  = 1'b0;
    reset = 1'b1;
    cyc(0, 0, 32'h0, 32'h0);
    check("post_release_idle", ldResult, 32'h0);

    cyc(0, 1, 32'h0, 32'h1234_5678);
    cyc(0, 1, 32'h4, 32'hDEAD_BEEF);
    check("store_no_ld_change", ldResult, 32'h0);
    cyc(1, 0, 32'h0, 32'h0);
    check("ld_0x0", ldResult, 32'h1234_5678);
    cyc(1, 0, 32'h4, 32'h0);
    check("ld_0x4", ldResult, 32'hDEAD_BEEF);

    cyc(0, 1, 32'h0, 32'hCAFE_F00D);
    check("ld_hold_during_store", ldResult, 32'hDEAD_BEEF);

    // Asynchronous reset mid-cycle, with a store attempted while held.
    #2;
    reset = 1'b0;
    #1;
    check("reset_async_midcycle", ldResult, 32'h0);
    cyc(1, 1, 32'h4, 32'hBADB_AD00);
    check("reset_blocks_load", ldResult, 32'h0);
    reset = 1'b1;
    cyc(0, 0, 32'h0, 32'h0);
    cyc(0, 1, 32'h4, 32'h0);
    check("post_reset_no_ld", ldResult, 32'h0);
    cyc(0, 1, 32'h4, 32'hDEAD_BEEF);
    cyc(1, 0, 32'h8, 32'h0);
    cyc(1, 0, 32'h0, 32'h0);
    check("store_while_idle_0x0", ldResult, 32'hCAFE_F00D);

    // Separate word: written only during reset, must remain unwritten value check via known data.
    cyc(0, 1, 32'h18, 32'h7777_7777);
    #1;
    reset = 1'b0;
    cyc(0, 1, 32'h18, 32'hBADB_AD00);
    reset = 1'b1;
    cyc(1, 0, 32'h18, 32'h0);
    check("reset_suppresses_store", ldResult, 32'h7777_7777);

    // Non-aligned.
    cyc(0, 1, 32'h1, 32'hAABB_CCDD);
    cyc(1, 0, 32'h1, 32'h0);
    check("ld_unaligned_0x1", ldResult, 32'hAABB_CCDD);
    cyc(1, 0, 32'h0, 32'h0);
    check("ld_aligned_same_word", ldResult, 32'hAABB_CCDD);
    cyc(1, 0, 32'h3, 32'h0);
    check("ld_unaligned_0x3", ldResult, 32'hAABB_CCDD);

    // Multiple words with holds between loads.
    cyc(0, 1, 32'h8,  32'h1111_1111);
    cyc(0, 1, 32'hC,  32'h2222_2222);
    cyc(0, 1, 32'h10, 32'h3333_3333);
    cyc(1, 0, 32'h8, 32'h0);
    check("ld_0x8", ldResult, 32'h1111_1111);
    cyc(0, 0, 32'hC, 32'h0);
    check("hold_0x8", ldResult, 32'h1111_1111);
    cyc(1, 0, 32'hC, 32'h0);
    check("ld_0xC", ldResult, 32'h2222_2222);
    cyc(0, 1, 32'h10, 32'h9999_9999);
    check("hold_0xC", ldResult, 32'h2222_2222);
    cyc(1, 0, 32'h10, 32'h0);
    check("ld_0x10", ldResult, 32'h9999_9999);

    // Simultaneous load/store: old word returned.
    cyc(0, 1, 32'h14, 32'h0);
    cyc(1, 1, 32'h14, 32'h4444_4444);
    check("rbw_old_word", ldResult, 32'h0);
    cyc(1, 0, 32'h14, 32'h0);
    check("rbw_new_word", ldResult, 32'h4444_4444);

    // Aliasing modulo 4 KB.
    cyc(0, 1, 32'h1000, 32'h55AA_55AA);
    cyc(1, 0, 32'h0, 32'h0);
    check("alias_0x1000", ldResult, 32'h55AA_55AA);
    cyc(1, 0, 32'hFFFF_F004, 32'h0);
    check("alias_high_0x4", ldResult, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, log2 of data-memory depth in 32-bit words (1024 words, 4 KB).
REQ-002 Port: Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: aluResult  input  32  byte address of the access, computed by the ALU.
REQ-005 Port: op2  input  32  store data.
REQ-006 Port: isLd  input  1  load enable, sampled at the rising edge of Clk.
REQ-007 Port: isSt  input  1  store enable, sampled at the rising edge of Clk.
REQ-008 Port: ldResult  output  32  registered load data.

Function
REQ-009 Block SHALL contain a word-organised data memory of 2**DEPTH_LOG2 x 32 bits.
REQ-010 Word index SHALL be aluResult[DEPTH_LOG2+1:2].
REQ-011 aluResult[1:0] SHALL be ignored; non-aligned accesses act on the containing aligned word.
REQ-012 aluResult bits above DEPTH_LOG2+1 SHALL be ignored, so addresses alias modulo memory size.
REQ-013 Store: at a rising edge with isSt=1, memory[index] SHALL take op2 (full 32-bit write; no byte enables).
REQ-014 Load: at a rising edge with isLd=1, ldResult SHALL take memory[index].
REQ-015 Load latency SHALL be one cycle: ldResult is valid immediately after the sampling edge.
REQ-016 ldResult SHALL hold its value until the next load edge or reset.
REQ-017 With isLd=0, ldResult SHALL NOT change, regardless of isSt, aluResult or op2.
REQ-018 With isSt=0, memory SHALL NOT change.
REQ-019 When isLd=1 and isSt=1 at the same edge, the store SHALL occur and ldResult SHALL take the pre-store (old) word (read-before-write).
REQ-020 A load on the edge after a store to the same word SHALL return the newly stored data.
REQ-021 No handshake, stall or error output exists; every enabled access completes in its cycle.

Reset
REQ-022 While reset=0, ldResult SHALL be 32'h0000_0000, asynchronously, independent of Clk.
REQ-023 While reset=0, stores SHALL be suppressed and memory contents SHALL be left unchanged.
REQ-024 Reset SHALL NOT initialise the memory array; contents are undefined until first written.
REQ-025 The first rising edge after reset goes to 1 SHALL operate normally.

Verification
REQ-026 Reset: reset=0 during a load cycle -> ldResult=0 immediately; after release with isLd=0, ldResult stays 0.
REQ-027 Store/load round trip:
- St 0x0 <- 0x12345678; St 0x4 <- 0xDEADBEEF.
- Ld 0x0 -> 0x12345678; Ld 0x4 -> 0xDEADBEEF, one cycle after each load edge.
REQ-028 Non-aligned access:
- St 0x1 <- 0xAABBCCDD, then Ld 0x1 -> 0xAABBCCDD.
- Ld 0x0 -> 0xAABBCCDD (same word).
REQ-029 Multiple words:
- St 0x8 <- 0x11111111, St 0xC <- 0x22222222, St 0x10 <- 0x33333333.
- Loads return those values in order; ldResult holds each between loads.
REQ-030 Simultaneous access: word 0x14 holds 0x0; isLd=isSt=1, op2=0x44444444 -> ldResult=0x0; next Ld 0x14 -> 0x44444444.
REQ-031 Aliasing: St 0x1000 <- 0x55AA55AA (DEPTH_LOG2=10) -> Ld 0x0 -> 0x55AA55AA.
